// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: write-back, write-allocate data-cache controller for a 2-way SRAM with miss writeback/refill FSM
module dcache_miss_ctrl #(
  parameter int WORD_W  = 32,
  parameter int LINE_W  = 256,
  parameter int INDEX_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [WORD_W-1:0]     cpu_data_i,
  input  logic                  cpu_MemRead_i,
  input  logic                  cpu_MemWrite_i,
  output logic [WORD_W-1:0]     cpu_data_o,
  output logic                  cpu_stall_o,
  output logic [INDEX_W-1:0]    sram_addr_o,
  output logic [31-INDEX_W-3:0] sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  input  logic [31-INDEX_W-3:0] sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i,
  output logic [31:0]           mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i
);
  localparam int TAG_W = 32 - INDEX_W - 5;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, FILLDONE} state_t;
  state_t state, state_nxt;
  logic req, hit, dirty, fill, unused_lsb;
  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] set;
  logic [2:0] word;
  logic [LINE_W-1:0] line;
  assign req        = cpu_MemRead_i | cpu_MemWrite_i;
  assign tag        = cpu_addr_i[31:32-TAG_W];
  assign set        = cpu_addr_i[INDEX_W+4:5];
  assign word       = cpu_addr_i[4:2];
  assign unused_lsb = ^cpu_addr_i[1:0];
  assign hit        = state == IDLE && sram_hit_i;
  assign dirty      = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
  assign fill       = state == REFILL && mem_ack_i;
  assign sram_addr_o = set;
  assign cpu_data_o  = sram_data_i[word*WORD_W +: WORD_W];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req && !sram_hit_i) state_nxt = MISS;
      MISS:      state_nxt = dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack_i) state_nxt = REFILL;
      REFILL:    if (mem_ack_i) state_nxt = FILLDONE;
      default:   state_nxt = IDLE;
    endcase
  end
  // A store hit merges into the line being read; a refill writes the raw memory line as clean.
  always_comb begin
    line = sram_data_i;
    line[word*WORD_W +: WORD_W] = cpu_data_i;
    cpu_stall_o   = req & ~hit;
    sram_enable_o = (state == IDLE || state == MISS) ? req : fill;
    sram_write_o  = fill | (hit & cpu_MemWrite_i);
    sram_tag_o    = {1'b1, ~fill, tag};
    sram_data_o   = fill ? mem_data_i : line;
  end
  // WRITEBACK hands straight over to the refill read so the request never drops between them.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else if (state == MISS) begin
      mem_enable_o <= 1'b1;
      mem_write_o  <= dirty;
      mem_addr_o   <= {dirty ? sram_tag_i[TAG_W-1:0] : tag, set, 5'b0};
      mem_data_o   <= sram_data_i;
    end else if (state == WRITEBACK && mem_ack_i) begin
      mem_write_o  <= 1'b0;
      mem_addr_o   <= {tag, set, 5'b0};
    end else if (fill) begin
      mem_enable_o <= 1'b0;
    end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: scoreboard bench with a behavioural 2-way SRAM and ack-delay memory model
module tb_dcache_miss_ctrl;
  logic clk_i = 0, rst_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0;
  logic cpu_MemRead_i = 0, cpu_MemWrite_i = 0;
  logic [31:0] cpu_data_o;
  logic cpu_stall_o;
  logic [3:0] sram_addr_o;
  logic [24:0] sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i, mem_data_o, mem_data_i;
  logic sram_enable_o, sram_write_o, sram_hit_i;
  logic [31:0] mem_addr_o;
  logic mem_enable_o, mem_write_o, mem_ack_i;

  dcache_miss_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
    .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic w; logic [31:0] a; logic [31:0] w1; } mem_t;
  typedef struct { logic [24:0] t; logic [31:0] w0; logic [31:0] w1; } sram_t;
  mem_t exp_mem[$];
  sram_t exp_sram[$];
  logic [31:0] exp_load[$];
  mem_t em;
  sram_t es;
  logic [31:0] el;
  int n_cmp = 0, n_err = 0;
  int ack_delay = 0, wait_cnt = 0;
  logic spur = 0;
  int stalls, en_cyc;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic bad(input string n);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event", n);
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 8'h00, 8'(k)};
    if (a == 32'h40) l[31:0] = 32'hDEADBEEF;
    return l;
  endfunction

  // Behavioural SRAM: hit way or LRU victim presented combinationally
  logic [24:0] st [16][2] = '{default: '0};
  logic [255:0] sd [16][2] = '{default: '0};
  logic lru [16] = '{default: 1'b0};
  logic h0, h1, way;
  always_comb begin
    h0 = st[sram_addr_o][0][24] && st[sram_addr_o][0][22:0] == cpu_addr_i[31:9];
    h1 = st[sram_addr_o][1][24] && st[sram_addr_o][1][22:0] == cpu_addr_i[31:9];
    way = h0 ? 1'b0 : h1 ? 1'b1 : lru[sram_addr_o];
    sram_hit_i = h0 | h1;
    sram_tag_i = st[sram_addr_o][way];
    sram_data_i = sd[sram_addr_o][way];
  end
  always @(posedge clk_i)
    if (sram_enable_o && (sram_hit_i || sram_write_o)) begin
      if (sram_write_o) begin
        st[sram_addr_o][way] <= sram_tag_o;
        sd[sram_addr_o][way] <= sram_data_o;
      end
      lru[sram_addr_o] <= ~way;
    end

  // Memory responder: acks after ack_delay cycles of a held request
  initial begin
    mem_ack_i = 0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 0;
      if (spur) mem_ack_i = 1;
      else if (mem_enable_o && rst_i) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack_i = 1;
          mem_data_i = line_of(mem_addr_o);
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a load result, memory transfer or SRAM write
  always @(negedge clk_i)
    if (rst_i) begin
      if (cpu_MemRead_i && !cpu_MemWrite_i && !cpu_stall_o) begin
        if (exp_load.size() == 0) bad("load_unexpected");
        else begin
          el = exp_load.pop_front();
          chk("load_data", cpu_data_o, el);
        end
      end
      if (mem_ack_i && mem_enable_o && !spur) begin
        if (exp_mem.size() == 0) bad("mem_unexpected");
        else begin
          em = exp_mem.pop_front();
          chk("mem_write", mem_write_o, em.w);
          chk("mem_addr", mem_addr_o, em.a);
          if (em.w) chk("mem_wb_word1", mem_data_o[63:32], em.w1);
        end
      end
      if (sram_enable_o && sram_write_o) begin
        if (exp_sram.size() == 0) bad("sram_write_unexpected");
        else begin
          es = exp_sram.pop_front();
          chk("sram_tag", sram_tag_o, es.t);
          chk("sram_word0", sram_data_o[31:0], es.w0);
          chk("sram_word1", sram_data_o[63:32], es.w1);
        end
      end
    end

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic wr,
                        output int stl, output int enc);
    logic done;
    @(posedge clk_i);
    #1;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_MemWrite_i = wr;
    cpu_MemRead_i = !wr;
    stl = 0;
    enc = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (mem_enable_o && !mem_ack_i) enc++;
      if (!cpu_stall_o) done = 1;
      else stl++;
    end
    if (!done) bad("access_timeout");
    @(posedge clk_i);
    #1;
    cpu_MemRead_i = 0;
    cpu_MemWrite_i = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    @(negedge clk_i);
    chk("rst_mem_enable", mem_enable_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_stall", cpu_stall_o, 0);
    // cold load, clean refill
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    exp_sram.push_back('{25'h1000000, 32'hDEADBEEF, 32'h00400001});
    exp_load.push_back(32'hDEADBEEF);
    access(32'h40, 0, 0, stalls, en_cyc);
    chk("t1_stall_cycles", stalls, 4);
    // store hit merges word1
    exp_sram.push_back('{25'h1800000, 32'hDEADBEEF, 32'h12345678});
    access(32'h44, 32'h12345678, 1, stalls, en_cyc);
    chk("t2_stall_cycles", stalls, 0);
    // fill second way, then evict the dirty line
    exp_mem.push_back('{1'b0, 32'h240, 32'h0});
    exp_sram.push_back('{25'h1000001, 32'h02400000, 32'h02400001});
    exp_load.push_back(32'h02400000);
    access(32'h240, 0, 0, stalls, en_cyc);
    chk("t3a_stall_cycles", stalls, 4);
    exp_mem.push_back('{1'b1, 32'h40, 32'h12345678});
    exp_mem.push_back('{1'b0, 32'h440, 32'h0});
    exp_sram.push_back('{25'h1000002, 32'h04400000, 32'h04400001});
    exp_load.push_back(32'h04400000);
    access(32'h440, 0, 0, stalls, en_cyc);
    chk("t3b_stall_cycles", stalls, 5);
    // slow memory: request held 10 cycles, then a hit
    ack_delay = 10;
    exp_mem.push_back('{1'b0, 32'hA0, 32'h0});
    exp_sram.push_back('{25'h1000000, 32'h00A00000, 32'h00A00001});
    exp_load.push_back(32'h00A00001);
    access(32'hA4, 0, 0, stalls, en_cyc);
    chk("t4_enable_held", en_cyc, 10);
    chk("t4_stall_cycles", stalls, 14);
    ack_delay = 0;
    exp_load.push_back(32'h00A00001);
    access(32'hA4, 0, 0, stalls, en_cyc);
    chk("t4_hit_stall", stalls, 0);
    // reset during REFILL
    ack_delay = 20;
    @(posedge clk_i);
    #1;
    cpu_addr_i = 32'h2C0;
    cpu_MemRead_i = 1;
    for (int i = 0; i < 10 && !mem_enable_o; i++) @(negedge clk_i);
    chk("t5_enable_before_rst", mem_enable_o, 1);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 0;
    #1;
    chk("t5_enable_async_drop", mem_enable_o, 0);
    cpu_MemRead_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    ack_delay = 0;
    exp_mem.push_back('{1'b0, 32'h2C0, 32'h0});
    exp_sram.push_back('{25'h1000001, 32'h02C00000, 32'h02C00001});
    exp_load.push_back(32'h02C00002);
    access(32'h2C8, 0, 0, stalls, en_cyc);
    chk("t5_stall_cycles", stalls, 4);
    // spurious acks with no request
    @(posedge clk_i);
    #2 spur = 1;
    repeat (5) begin
      @(negedge clk_i);
      chk("t6_stall", cpu_stall_o, 0);
      chk("t6_sram_write", sram_write_o, 0);
      chk("t6_mem_enable", mem_enable_o, 0);
    end
    @(posedge clk_i);
    #2 spur = 0;
    exp_load.push_back(32'h00A00001);
    access(32'hA4, 0, 0, stalls, en_cyc);
    chk("t6_hit_stall", stalls, 0);
    repeat (2) @(posedge clk_i);
    chk("left_mem", exp_mem.size(), 0);
    chk("left_sram", exp_sram.size(), 0);
    chk("left_load", exp_load.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
